// File: rtl/delta_demodulator.sv
// Delta-modulation spike decoder: saturating reconstruction register, sticky
// illegal-code flag and saturating event counter. Optional macro DEMOD_LEAK_EN adds an idle leak toward mid-scale.
module delta_demodulator #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned LEAK_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spike_valid_i,
    input  logic [1:0]           spike_i,
    input  logic [WIDTH-1:0]     step_i,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     load_value_i,
    input  logic                 clr_i,
    output logic [WIDTH-1:0]     recon_o,
    output logic                 recon_valid_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] event_cnt_o
);

    localparam logic [1:0] SPK_NONE = 2'b00;
    localparam logic [1:0] SPK_DOWN = 2'b01;
    localparam logic [1:0] SPK_UP   = 2'b10;
    localparam logic [1:0] SPK_ILL  = 2'b11;

    localparam logic [WIDTH-1:0]     RECON_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    logic [WIDTH-1:0]     recon_q, recon_d;
    logic                 recon_valid_q, recon_valid_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] event_cnt_q, event_cnt_d;

    logic                 accept_c;
    logic                 move_c;
    logic [WIDTH:0]       sum_c;
    logic                 leak_fire_c;
    logic [WIDTH-1:0]     leak_value_c;
    logic                 leak_moves_c;

    assign accept_c = spike_valid_i && !load_i;
    assign move_c   = accept_c && ((spike_i == SPK_UP) || (spike_i == SPK_DOWN));
    assign sum_c    = {1'b0, recon_q} + {1'b0, step_i};

`ifdef DEMOD_LEAK_EN
    localparam int unsigned          IDLE_W    = (LEAK_CYCLES < 2) ? 1 : $clog2(LEAK_CYCLES);
    localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(LEAK_CYCLES - 1);
    localparam logic [WIDTH-1:0]     RECON_MID = {1'b1, {(WIDTH-1){1'b0}}};

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              leak_due_c;

    assign leak_due_c  = (idle_q == IDLE_LAST);
    assign leak_fire_c = leak_due_c && !load_i && !accept_c;

    // Idle counter; an accepted no-move sample defers a due leak to the next idle cycle
    always_comb begin
        idle_d = idle_q;
        if (load_i || move_c) begin
            idle_d = '0;
        end else if (leak_due_c) begin
            idle_d = accept_c ? idle_q : '0;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_comb begin
        leak_value_c = recon_q;
        leak_moves_c = 1'b0;
        if (recon_q > RECON_MID) begin
            leak_value_c = recon_q - WIDTH'(1);
            leak_moves_c = 1'b1;
        end else if (recon_q < RECON_MID) begin
            leak_value_c = recon_q + WIDTH'(1);
            leak_moves_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_leak_cfg;

    assign unused_leak_cfg = ^LEAK_CYCLES;
    assign leak_fire_c     = 1'b0;
    assign leak_value_c    = recon_q;
    assign leak_moves_c    = 1'b0;
`endif

    // Next-state: load > accepted sample > leak, then clr overrides err/count
    always_comb begin
        recon_d       = recon_q;
        recon_valid_d = 1'b0;
        err_d         = err_q;
        event_cnt_d   = event_cnt_q;

        if (load_i) begin
            recon_d       = load_value_i;
            recon_valid_d = 1'b1;
        end else if (accept_c) begin
            recon_valid_d = 1'b1;
            case (spike_i)
                SPK_UP: begin
                    recon_d = sum_c[WIDTH] ? RECON_MAX : sum_c[WIDTH-1:0];
                end
                SPK_DOWN: begin
                    recon_d = (step_i > recon_q) ? '0 : (recon_q - step_i);
                end
                SPK_ILL: begin
                    err_d = 1'b1;
                end
                SPK_NONE: begin
                    recon_d = recon_q;
                end
                default: begin
                    recon_d = recon_q;
                end
            endcase
            if (move_c && (event_cnt_q != CNT_MAX)) begin
                event_cnt_d = event_cnt_q + CNT_WIDTH'(1);
            end
        end else if (leak_fire_c && leak_moves_c) begin
            recon_d       = leak_value_c;
            recon_valid_d = 1'b1;
        end

        if (clr_i) begin
            err_d       = 1'b0;
            event_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            recon_q       <= '0;
            recon_valid_q <= 1'b0;
            err_q         <= 1'b0;
            event_cnt_q   <= '0;
        end else begin
            recon_q       <= recon_d;
            recon_valid_q <= recon_valid_d;
            err_q         <= err_d;
            event_cnt_q   <= event_cnt_d;
        end
    end

    assign recon_o       = recon_q;
    assign recon_valid_o = recon_valid_q;
    assign err_o         = err_q;
    assign event_cnt_o   = event_cnt_q;

endmodule

// File: tb/tb_delta_demodulator.sv
// Directed self-checking bench for delta_demodulator (WIDTH=4, CNT_WIDTH=8, LEAK_CYCLES=8).
module tb_delta_demodulator;

    logic       clk;
    logic       reset;
    logic       spike_valid_i;
    logic [1:0] spike_i;
    logic [3:0] step_i;
    logic       load_i;
    logic [3:0] load_value_i;
    logic       clr_i;
    logic [3:0] recon_o;
    logic       recon_valid_o;
    logic       err_o;
    logic [7:0] event_cnt_o;

    int total;
    int bad;

    delta_demodulator #(
        .WIDTH      (4),
        .CNT_WIDTH  (8),
        .LEAK_CYCLES(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spike_valid_i(spike_valid_i),
        .spike_i      (spike_i),
        .step_i       (step_i),
        .load_i       (load_i),
        .load_value_i (load_value_i),
        .clr_i        (clr_i),
        .recon_o      (recon_o),
        .recon_valid_o(recon_valid_o),
        .err_o        (err_o),
        .event_cnt_o  (event_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset         = 1'b0;
        spike_valid_i = 1'b0;
        spike_i       = 2'b00;
        step_i        = 4'd0;
        load_i        = 1'b0;
        load_value_i  = 4'd0;
        clr_i         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({recon_o, recon_valid_o, err_o, event_cnt_o} !== 14'd0) begin
            bad++;
            $display("FAIL reset_state: got recon=%0d v=%0b err=%0b cnt=%0d, want all 0",
                     recon_o, recon_valid_o, err_o, event_cnt_o);
        end
    endtask

    task automatic test_up_steps();
        logic [3:0] exp;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            spike_valid_i = 1'b1; spike_i = 2'b10; step_i = 4'd3;
            tick();
            exp = 4'(3 * i);
            total++;
            if (recon_o !== exp || recon_valid_o !== 1'b1) begin
                bad++;
                $display("FAIL up_step%0d: got recon=%0d v=%0b, want recon=%0d v=1",
                         i, recon_o, recon_valid_o, exp);
            end
        end
        idle_inputs();
        tick();
        total++;
        if (recon_o !== 4'd9 || recon_valid_o !== 1'b0 || event_cnt_o !== 8'd3 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL up_idle: got recon=%0d v=%0b cnt=%0d err=%0b, want 9 0 3 0",
                     recon_o, recon_valid_o, event_cnt_o, err_o);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_r [3];
        exp_r[0] = 4'd15; exp_r[1] = 4'd0; exp_r[2] = 4'd0;
        do_reset();
        load_i = 1'b1; load_value_i = 4'd14;
        tick();
        total++;
        if (recon_o !== 4'd14 || recon_valid_o !== 1'b1 || event_cnt_o !== 8'd0) begin
            bad++;
            $display("FAIL sat_load: got recon=%0d v=%0b cnt=%0d, want 14 1 0",
                     recon_o, recon_valid_o, event_cnt_o);
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            spike_valid_i = 1'b1;
            spike_i = (i == 0) ? 2'b10 : 2'b01;
            step_i  = (i == 0) ? 4'd5 : 4'd15;
            tick();
            total++;
            if (recon_o !== exp_r[i] || recon_valid_o !== 1'b1 || err_o !== 1'b0) begin
                bad++;
                $display("FAIL sat_step%0d: got recon=%0d v=%0b err=%0b, want %0d 1 0",
                         i, recon_o, recon_valid_o, err_o, exp_r[i]);
            end
        end
        idle_inputs();
        total++;
        if (event_cnt_o !== 8'd3) begin
            bad++;
            $display("FAIL sat_count: got cnt=%0d, want 3", event_cnt_o);
        end
    endtask

    task automatic test_illegal_and_clr();
        do_reset();
        spike_valid_i = 1'b1; spike_i = 2'b10; step_i = 4'd2;
        tick();
        idle_inputs();
        load_i = 1'b1; load_value_i = 4'd7;
        tick();
        idle_inputs();
        spike_valid_i = 1'b1; spike_i = 2'b11; step_i = 4'd4;
        tick();
        total++;
        if (recon_o !== 4'd7 || recon_valid_o !== 1'b1 || err_o !== 1'b1 || event_cnt_o !== 8'd1) begin
            bad++;
            $display("FAIL illegal: got recon=%0d v=%0b err=%0b cnt=%0d, want 7 1 1 1",
                     recon_o, recon_valid_o, err_o, event_cnt_o);
        end
        idle_inputs();
        tick();
        total++;
        if (err_o !== 1'b1 || recon_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL err_sticky: got err=%0b v=%0b, want 1 0", err_o, recon_valid_o);
        end
        clr_i = 1'b1;
        tick();
        total++;
        if (err_o !== 1'b0 || event_cnt_o !== 8'd0 || recon_o !== 4'd7) begin
            bad++;
            $display("FAIL clr: got err=%0b cnt=%0d recon=%0d, want 0 0 7", err_o, event_cnt_o, recon_o);
        end
        // clr with a concurrent up spike: counter stays cleared, recon still moves
        spike_valid_i = 1'b1; spike_i = 2'b10; step_i = 4'd1;
        tick();
        total++;
        if (event_cnt_o !== 8'd0 || recon_o !== 4'd8 || recon_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL clr_spike: got cnt=%0d recon=%0d v=%0b, want 0 8 1",
                     event_cnt_o, recon_o, recon_valid_o);
        end
        idle_inputs();
    endtask

    task automatic test_load_priority();
        do_reset();
        spike_valid_i = 1'b1; spike_i = 2'b10; step_i = 4'd1;
        tick();
        load_i = 1'b1; load_value_i = 4'd2; step_i = 4'd4;
        tick();
        total++;
        if (recon_o !== 4'd2 || recon_valid_o !== 1'b1 || event_cnt_o !== 8'd1) begin
            bad++;
            $display("FAIL load_prio: got recon=%0d v=%0b cnt=%0d, want 2 1 1",
                     recon_o, recon_valid_o, event_cnt_o);
        end
        load_i = 1'b0; spike_i = 2'b11;
        tick();
        spike_i = 2'b10; reset = 1'b1;
        tick();
        total++;
        if ({recon_o, recon_valid_o, err_o, event_cnt_o} !== 14'd0) begin
            bad++;
            $display("FAIL reset_mid: got recon=%0d v=%0b err=%0b cnt=%0d, want all 0",
                     recon_o, recon_valid_o, err_o, event_cnt_o);
        end
        idle_inputs();
    endtask

    task automatic test_count_saturate();
        do_reset();
        load_i = 1'b1; load_value_i = 4'd5;
        tick();
        idle_inputs();
        for (int i = 1; i <= 260; i++) begin
            spike_valid_i = 1'b1; spike_i = 2'b01; step_i = 4'd0;
            tick();
            if (i == 255) begin
                total++;
                if (event_cnt_o !== 8'd255 || recon_o !== 4'd5) begin
                    bad++;
                    $display("FAIL cnt_255: got cnt=%0d recon=%0d, want 255 5", event_cnt_o, recon_o);
                end
            end
        end
        total++;
        if (event_cnt_o !== 8'd255 || recon_o !== 4'd5 || recon_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL cnt_sat: got cnt=%0d recon=%0d v=%0b, want 255 5 1",
                     event_cnt_o, recon_o, recon_valid_o);
        end
        spike_valid_i = 1'b0; spike_i = 2'b11; step_i = 4'd7;
        tick();
        total++;
        if (err_o !== 1'b0 || recon_valid_o !== 1'b0 || recon_o !== 4'd5) begin
            bad++;
            $display("FAIL invalid_ignored: got err=%0b v=%0b recon=%0d, want 0 0 5",
                     err_o, recon_valid_o, recon_o);
        end
        idle_inputs();
    endtask

    task automatic test_leak();
        logic [3:0] exp_r;
        logic       exp_v;
        int         dec;
        do_reset();
        load_i = 1'b1; load_value_i = 4'd12;
        tick();
        idle_inputs();
        for (int k = 1; k <= 48; k++) begin
            tick();
`ifdef DEMOD_LEAK_EN
            dec   = k / 8;
            exp_r = (dec >= 4) ? 4'd8 : 4'(12 - dec);
            exp_v = (k % 8 == 0) && (k <= 32);
`else
            dec   = 0;
            exp_r = 4'd12;
            exp_v = 1'b0;
`endif
            if (k % 4 == 0) begin
                total++;
                if (recon_o !== exp_r || recon_valid_o !== exp_v) begin
                    bad++;
                    $display("FAIL leak_k%0d: got recon=%0d v=%0b, want %0d %0b",
                             k, recon_o, recon_valid_o, exp_r, exp_v);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        test_reset();
        test_up_steps();
        test_saturation();
        test_illegal_and_clr();
        test_load_priority();
        test_count_saturate();
        test_leak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delta_demodulator.md
Name: delta_demodulator

Overview:
Reconstructs a WIDTH-bit sample stream from the 2-bit up/down spike stream produced by the team's delta-modulation encoder. Keeps a running reconstruction register that moves by a programmable step on each accepted spike, with saturation. Also keeps an illegal-code flag and a spike event counter. Sits on the receive side of the spike link, either on-chip behind the encoder or as a standalone decoder driven from I/O pins.

Parameters:
WIDTH, 4, width of the reconstruction, step and load values
CNT_WIDTH, 8, width of the saturating spike event counter
LEAK_CYCLES, 8, idle cycles before one leak step (used only with DEMOD_LEAK_EN)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
spike_valid  in  1  spike qualifier; spike is sampled only when high
spike  in  2  [1]=up, [0]=down; 2'b00 = no change, 2'b11 = illegal
step  in  WIDTH  magnitude of one spike, sampled together with spike
load  in  1  force reconstruction to load_value
load_value  in  WIDTH  preset value
clr  in  1  clears err and event_cnt
recon  out  WIDTH  reconstructed sample (registered)
recon_valid  out  1  one-cycle pulse: recon updated from an accepted sample or load
err  out  1  sticky illegal-code flag
event_cnt  out  CNT_WIDTH  saturating count of accepted up/down spikes

Behaviour:
- Reset, synchronous, evaluated on posedge clk:
  - recon = 0, recon_valid = 0, err = 0, event_cnt = 0, internal idle counter = 0.
  - Reset overrides every other input in the same cycle.
- Priority each cycle: reset > load > accepted spike > leak.
- Load:
  - recon <= load_value and recon_valid <= 1 on the next edge.
  - Any spike in the same cycle is dropped; event_cnt and err do not change from it.
- Accepted sample = spike_valid high and load low. Latency is 1 cycle: recon and recon_valid reflect the sample on the edge after it is presented.
  - spike = 2'b10: sum = recon + step, computed at WIDTH+1 bits. recon <= all-ones if the sum exceeds 2^WIDTH-1, else the sum.
  - spike = 2'b01: recon <= 0 if step > recon, else recon - step.
  - spike = 2'b00: recon holds.
  - spike = 2'b11: recon holds; err <= 1.
  - recon_valid <= 1 for every accepted sample, including 00 and 11.
- Boundary conditions:
  - step = 0 is legal; recon holds but the spike is still counted.
  - Saturation does not set err.
- event_cnt:
  - Increments by 1 on every accepted 10 or 01.
  - Saturates at all-ones; does not wrap.
- clr:
  - Same edge: err <= 0 and event_cnt <= 0.
  - If an accepted spike is also present, clr wins for event_cnt and err; recon still updates.
- recon_valid is low in every cycle with no load and no accepted sample.
- spike_valid low: spike and step are don't-care.

Optional Feature:
DEMOD_LEAK_EN
- Defined:
  - The idle counter increments each cycle with no load and no accepted 10 or 01.
  - When it reaches LEAK_CYCLES, recon moves 1 toward MID = 2^(WIDTH-1), recon_valid pulses and the counter clears.
  - No leak step occurs when recon equals MID; the counter still clears.
  - Load or an accepted 10/01 clears the counter.
  - A leak never coincides with a spike update, because the spike has priority.
- Not defined:
  - No idle counter exists; recon holds indefinitely between spikes.
  - LEAK_CYCLES is ignored.

Test Plan:
1. Reset, then 3 accepted 10 with step=3 -> recon 3, 6, 9, each one cycle after its sample; recon_valid pulses 3 times; event_cnt=3; err=0.
2. load with load_value=14, then 10 with step=5 -> recon 14, then 15 (saturated); then 01 with step=15 twice -> 0, 0 (floor); event_cnt=3.
3. Accepted spike=11 with recon=7 -> recon stays 7, recon_valid=1, err=1 and stays 1; clr next cycle -> err=0, event_cnt=0.
4. load=1 with load_value=2 in the same cycle as a valid 10 with step=4 -> recon=2, event_cnt unchanged; reset asserted mid-stream with a valid 10 -> all outputs 0 on the next edge.
5. 260 accepted 01 samples with step=0 -> recon unchanged, event_cnt saturates at 255; spike_valid=0 with spike=11 -> no err, no recon_valid.
6. DEMOD_LEAK_EN defined, LEAK_CYCLES=8, load_value=12, then idle -> recon 11 after 8 idle cycles, 10 after 16, reaches 8 and holds; same stimulus without the macro -> recon stays 12.
